cla_adder_pipe: RTL and testbench
=================================

# cla_adder_pipe

Parametrised, pipelined carry-lookahead adder: the next generation of the fixed 6-bit CLA. Adds two WIDTH-bit operands plus carry-in. Splits the carry chain into STAGES registered segments and moves operands through the pipeline with a valid/ready handshake, so it can sit in the fabric's arithmetic datapath between streaming producers and consumers. Also reports carry-out and signed overflow.

## Interface
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES
- STAGES, 4, pipeline stages (segments); 1 ≤ STAGES ≤ WIDTH
- GROUP, 4, lookahead group size inside a segment; must divide WIDTH/STAGES; structural only, no functional effect
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- ain  in  WIDTH  operand A
- bin  in  WIDTH  operand B
- cin  in  1  carry-in
- sub  in  1  subtract request (present only with CLA_SUB_EN)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out of MSB
- ovf  out  1  signed overflow (carry into MSB XOR carry out of MSB)

## Operation
- Segment width SEG = WIDTH/STAGES. Stage k (0..STAGES-1) computes bits [k*SEG +: SEG] using CLA groups of GROUP bits, from the carry registered by stage k-1 (stage 0 uses the effective carry-in).
- Per-group: p = a^b, g = a&b, c[i+1] = g[i] | p[i]&c[i], expanded as lookahead within the group; group carries ripple across groups within a segment; sum = p ^ c.
- Each stage register holds: valid bit, completed low sum bits, remaining unprocessed operand bits, segment carry-out. For the last stage it also holds the carry into the MSB, which is needed for ovf.
- Results are exact modulo 2^WIDTH; cout = bit WIDTH of ain+bin+cin.
- Handshake per stage: ready_k = !valid_k | ready_{k+1}; ready_STAGES = out_ready; in_ready = ready_0 (combinational).
- A transfer occurs on a cycle where valid & ready are both high. A stage loads upstream data when ready_k. Its valid becomes the upstream valid.
- Order is preserved. There is no dropping and no duplication. Full throughput is one result per cycle.
- out_valid, sum, cout and ovf come from the last stage register. They hold stable while out_valid & !out_ready.

## Timing
- Reset: all stage valids 0; out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 the cycle after reset deasserts (out_ready independent).
- Latency: operands accepted at edge N → out_valid=1 after edge N+STAGES-1 (STAGES=1: registered once, visible after edge N).
- in_ready low only when every stage is valid and out_ready=0.
- Stall: out_ready=0 with pipe full → nothing advances, in_ready=0; release → one result drains per cycle, and new input is accepted in the same cycle.
- Bubbles: in_valid gaps propagate as invalid slots; they are not compacted unless downstream is stalled.
- Simultaneous accept and drain on a full pipe is legal and keeps it full.
- rst mid-operation discards all in-flight data at the next edge; no result is emitted for it.

## Configuration
- CLA_SUB_EN defined: `sub` port exists. When sub=1 the operand becomes ~bin and the effective carry-in is forced to 1 (cin ignored), giving ain-bin. cout=1 means no borrow. ovf is signed overflow of the subtraction. sub is sampled with the operands.
- Undefined: no `sub` port; the block only adds, and effective carry-in = cin.

## Test plan
- Defaults: reset, then ain=0xFFFF_FFFF, bin=0x0000_0001, cin=0 → after 4 cycles sum=0x0000_0000, cout=1, ovf=0.
- ain=0x7FFF_FFFF, bin=1, cin=0 → sum=0x8000_0000, cout=0, ovf=1; ain=0x8000_0000, bin=0x8000_0000 → sum=0, cout=1, ovf=1.
- Stream of 100 random vectors with in_valid=1 and out_ready=1 → one result per cycle, in order, matching ain+bin+cin, after the first 4-cycle fill.
- Fill the pipe, then hold out_ready=0 for 5 cycles → in_ready=0 and sum held stable; release → 4 results in order, with no loss.
- Assert rst with 3 items in flight → next cycle out_valid=0 and sum=0; the next accepted item produces the only subsequent result.
- CLA_SUB_EN defined: ain=5, bin=7, sub=1 → sum=0xFFFF_FFFE, cout=0, ovf=0; ain=0x8000_0000, bin=1, sub=1 → sum=0x7FFF_FFFF, ovf=1.

Source files
------------

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder with valid/ready flow control, carry-out and signed overflow.
// Optional subtract mode is enabled by defining CLA_SUB_EN (adds the `sub` port).
module cla_adder_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4,
    parameter int unsigned GROUP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             cin,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned NGRP = SEG / GROUP;
    localparam int unsigned LAST = STAGES - 1;

    // Per-stage registers: low sum bits done so far, operands still to process, segment carry.
    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic              ovf_q;

    logic [WIDTH-1:0]  a_nx [STAGES];
    logic [WIDTH-1:0]  b_nx [STAGES];
    logic [WIDTH-1:0]  s_nx [STAGES];
    logic [STAGES-1:0] c_nx;
    logic              cm_nx;
    logic [STAGES-1:0] up_v;
    logic [STAGES-1:0] rdy;

    logic [WIDTH-1:0]  b_eff;
    logic              c_eff;
    logic [WIDTH-1:0]  pa;
    logic [WIDTH-1:0]  pb;
    logic [WIDTH-1:0]  ps;
    logic              pc;
    logic              pv;
    logic [GROUP-1:0]  gp;
    logic [GROUP-1:0]  gg;
    logic [GROUP:0]    gc;
    int unsigned       base;
    logic              racc;

    // Lookahead carries of one group: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci.
    function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] p,
                                                 input logic [GROUP-1:0] g,
                                                 input logic             ci);
        logic [GROUP:0] c;
        logic           acc;
        logic           pp;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < int'(GROUP); i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & ci);
        end
        return c;
    endfunction

`ifdef CLA_SUB_EN
    assign b_eff = sub ? ~bin : bin;
    assign c_eff = sub | cin;
`else
    assign b_eff = bin;
    assign c_eff = cin;
`endif

    // Each stage adds its segment on top of whatever its upstream register (or the ports) holds.
    always_comb begin
        pa    = ain;
        pb    = b_eff;
        ps    = '0;
        pc    = c_eff;
        pv    = in_valid;
        cm_nx = 1'b0;
        c_nx  = '0;
        up_v  = '0;
        gp    = '0;
        gg    = '0;
        gc    = '0;
        base  = 0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            a_nx[k] = pa;
            b_nx[k] = pb;
            s_nx[k] = ps;
            up_v[k] = pv;
            for (int unsigned grp = 0; grp < NGRP; grp++) begin
                base = k * SEG + grp * GROUP;
                gp   = pa[base +: GROUP] ^ pb[base +: GROUP];
                gg   = pa[base +: GROUP] & pb[base +: GROUP];
                gc   = cla_group(gp, gg, pc);
                s_nx[k][base +: GROUP] = gp ^ gc[GROUP-1:0];
                pc   = gc[GROUP];
                if (k == LAST && grp == NGRP - 1) begin
                    cm_nx = gc[GROUP-1];
                end
            end
            c_nx[k] = pc;
            pa = a_q[k];
            pb = b_q[k];
            ps = s_q[k];
            pc = c_q[k];
            pv = v_q[k];
        end
    end

    // A stage may load when it is empty or the stage after it is moving.
    always_comb begin
        rdy  = '0;
        racc = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            racc   = ~v_q[k] | racc;
            rdy[k] = racc;
        end
    end

    assign in_ready = rdy[0];

    // Data registers only load on a real item so bubbles leave the held result untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= up_v[k];
                    if (up_v[k]) begin
                        a_q[k] <= a_nx[k];
                        b_q[k] <= b_nx[k];
                        s_q[k] <= s_nx[k];
                        c_q[k] <= c_nx[k];
                        if (k == LAST) begin
                            ovf_q <= c_nx[k] ^ cm_nx;
                        end
                    end
                end
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe: directed table, random stream, stall, mid-flight reset.
// Subtract vectors are included when CLA_SUB_EN is defined.
module tb_cla_adder_pipe;

    localparam int unsigned W  = 32;
    localparam int unsigned ST = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] ain;
    logic [W-1:0] bin;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int passes = 0;
    int n_out  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic        s;
        logic [31:0] sm;
        logic        co;
        logic        ov;
    } vec_t;

    typedef struct packed {
        logic        ov;
        logic        co;
        logic [31:0] sm;
    } res_t;

    vec_t tbl[$];
    res_t exp_q[$];

    always #5 clk = ~clk;

    cla_adder_pipe #(.WIDTH(W), .STAGES(ST), .GROUP(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ain      (ain),
        .bin      (bin),
        .cin      (cin),
`ifdef CLA_SUB_EN
        .sub      (sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input logic s);
        logic [31:0] bb;
        logic        cc;
        logic [32:0] r;
        res_t        e;
        bb   = s ? ~b : b;
        cc   = s ? 1'b1 : c;
        r    = 33'(a) + 33'(bb) + 33'(cc);
        e.sm = r[31:0];
        e.co = r[32];
        e.ov = (a[31] == bb[31]) && (r[31] != a[31]);
        return e;
    endfunction

    function automatic logic rand_sub();
`ifdef CLA_SUB_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    // One clock: drive, settle, score handshakes, advance to next falling edge.
    task automatic sb_cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic c, input logic s, input logic ordy, output logic acc);
        res_t e;
        in_valid  = v;
        ain       = a;
        bin       = b;
        cin       = c;
        sub       = s;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected result", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sb sum", 64'(sum), 64'(e.sm));
                chk("sb cout", 64'(cout), 64'(e.co));
                chk("sb ovf", 64'(ovf), 64'(e.ov));
            end
            n_out++;
        end
        if (acc) exp_q.push_back(model(a, b, c, s));
        @(negedge clk);
    endtask

    task automatic rand_cycle(input logic v, input logic ordy, output logic acc);
        sb_cycle(v, $urandom, $urandom, 1'($urandom_range(0, 1)), rand_sub(), ordy, acc);
    endtask

    initial begin
        int          lat;
        int          n0;
        int          iters;
        int          sent;
        int          stalls;
        int          nacc;
        int          k;
        logic        acc;
        logic [31:0] held;

        tbl.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
        tbl.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
        tbl.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
        tbl.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0});
        tbl.push_back('{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0});
        tbl.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0});
        tbl.push_back('{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0});
        tbl.push_back('{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
        tbl.push_back('{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
`ifdef CLA_SUB_EN
        tbl.push_back('{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0});
        tbl.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1});
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        ain       = '0;
        bin       = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset out_valid", 64'(out_valid), 64'(0));
        chk("reset sum", 64'(sum), 64'(0));
        chk("reset cout", 64'(cout), 64'(0));
        chk("reset ovf", 64'(ovf), 64'(0));
        @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'(1));

        // Directed vectors, one at a time, with latency measurement.
        foreach (tbl[i]) begin
            in_valid  = 1'b1;
            ain       = tbl[i].a;
            bin       = tbl[i].b;
            cin       = tbl[i].c;
            sub       = tbl[i].s;
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            lat      = 0;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk("vec latency", 64'(lat), 64'(ST - 1));
            chk("vec sum", 64'(sum), 64'(tbl[i].sm));
            chk("vec cout", 64'(cout), 64'(tbl[i].co));
            chk("vec ovf", 64'(ovf), 64'(tbl[i].ov));
            @(negedge clk);
        end

        // Full-rate random stream.
        n0     = n_out;
        iters  = 0;
        sent   = 0;
        stalls = 0;
        while ((n_out - n0) < 100 && iters < 400) begin
            rand_cycle(sent < 100, 1'b1, acc);
            if (sent < 100 && !acc) stalls++;
            if (acc) sent++;
            iters++;
        end
        chk("stream results", 64'(n_out - n0), 64'(100));
        chk("stream cycles", 64'(iters), 64'(100 + ST));
        chk("stream stalls", 64'(stalls), 64'(0));

        // Fill under back-pressure, hold, then release with a simultaneous accept.
        n0   = n_out;
        nacc = 0;
        k    = 0;
        do begin
            rand_cycle(1'b1, 1'b0, acc);
            if (acc) nacc++;
            k++;
        end while (acc && k < 20);
        chk("fill accepted", 64'(nacc), 64'(ST));
        held = sum;
        for (int i = 0; i < 5; i++) begin
            rand_cycle(1'b1, 1'b0, acc);
            chk("stall accept", 64'(acc), 64'(0));
            chk("stall in_ready", 64'(in_ready), 64'(0));
            chk("stall out_valid", 64'(out_valid), 64'(1));
            chk("stall sum", 64'(sum), 64'(held));
        end
        rand_cycle(1'b1, 1'b1, acc);
        chk("accept on drain", 64'(acc), 64'(1));
        k = 0;
        while (exp_q.size() > 0 && k < 20) begin
            rand_cycle(1'b0, 1'b1, acc);
            k++;
        end
        chk("stall drained", 64'(n_out - n0), 64'(ST + 1));

        // Reset with three items in flight.
        n0 = n_out;
        for (int i = 0; i < 3; i++) rand_cycle(1'b1, 1'b1, acc);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        chk("midrst out_valid", 64'(out_valid), 64'(0));
        chk("midrst sum", 64'(sum), 64'(0));
        chk("midrst in_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 6; i++) rand_cycle(1'b0, 1'b1, acc);
        sb_cycle(1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b0, 1'b1, acc);
        k = 0;
        while (exp_q.size() > 0 && k < 20) begin
            rand_cycle(1'b0, 1'b1, acc);
            k++;
        end
        for (int i = 0; i < 5; i++) rand_cycle(1'b0, 1'b1, acc);
        chk("post-reset results", 64'(n_out - n0), 64'(1));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
